board_position_file: RTL and testbench

- Parametrised board-state store, successor to the fixed nine-cell, two-player position registers.
- Accepts moves over a valid/ready handshake and validates each move internally: range, occupancy and player ID.
- Tracks the move count and the full-board condition, and keeps an undo history stack.
- Sits between the player/computer move generators and the win-detection and display logic.

---
 rtl/board_position_file.sv | 210 +++++++++++++++++++++
 tb/tb_board_position_file.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_position_file.sv
// Board-state store: validates and commits moves over a valid/ready handshake,
// tracks move count and full-board status, and keeps a circular undo history.
module board_position_file #(
  parameter int unsigned CELLS      = 9,
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned PW         = 2,
  parameter int unsigned IW         = 4,
  parameter int unsigned HIST_DEPTH = 9,
  parameter int unsigned CW         = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                mv_valid,
  output logic                mv_ready,
  input  logic [IW-1:0]       mv_cell,
  input  logic [PW-1:0]       mv_player,
  input  logic                undo_req,
  output logic                mv_accept,
  output logic                mv_illegal,
  output logic [1:0]          illegal_code,
  output logic                undo_done,
  output logic                undo_err,
  output logic [CELLS*PW-1:0] board,
  output logic [CW-1:0]       move_count,
  output logic                board_full,
  output logic [IW-1:0]       last_cell,
  output logic [PW-1:0]       last_player
);

  localparam int unsigned EW = IW + PW;
  localparam int unsigned HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int unsigned NW = $clog2(HIST_DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StCheck} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        req_cell_q;
  logic [PW-1:0]        req_player_q;
  logic [CELLS*PW-1:0]  board_q, board_d;
  logic [CW-1:0]        count_q, count_d;
  logic [EW-1:0]        hist_q [HIST_DEPTH];
  logic [HW-1:0]        hist_ptr_q, hist_ptr_d;
  logic [NW-1:0]        hist_cnt_q, hist_cnt_d;
  logic                 hist_wr_en;
  logic [IW-1:0]        last_cell_q, last_cell_d;
  logic [PW-1:0]        last_player_q, last_player_d;
  logic [1:0]           code_q, code_d;
  logic                 accept_q, accept_d, illegal_q, illegal_d;
  logic                 undo_done_q, undo_done_d, undo_err_q, undo_err_d;

  logic                 range_bad, player_bad, occupied;
  logic [HW-1:0]        top_idx, below_idx;
  logic [EW-1:0]        top_entry, below_entry;

  function automatic logic [HW-1:0] ptr_inc(input logic [HW-1:0] p);
    return (p == HW'(HIST_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [HW-1:0] ptr_dec(input logic [HW-1:0] p);
    return (p == '0) ? HW'(HIST_DEPTH - 1) : p - 1'b1;
  endfunction

  // Legality of the captured request; the cell read is only meaningful when in range
  assign range_bad  = 32'(req_cell_q) >= CELLS;
  assign player_bad = (req_player_q == '0) || (32'(req_player_q) > PLAYERS);
  assign occupied   = board_q[32'(req_cell_q)*PW +: PW] != '0;

  // Pointer points at the next free slot, so the top entry sits one below it
  assign top_idx     = ptr_dec(hist_ptr_q);
  assign below_idx   = ptr_dec(top_idx);
  assign top_entry   = hist_q[top_idx];
  assign below_entry = hist_q[below_idx];

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic: clear always forces IDLE
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (mv_valid && mv_ready) state_d = StCheck;
        StCheck: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Handshake output
  always_comb begin
    mv_ready = (state_q == StIdle) && !clear && !undo_req;
  end

  // Datapath next-state: clear > pending check > undo
  always_comb begin
    board_d       = board_q;
    count_d       = count_q;
    hist_ptr_d    = hist_ptr_q;
    hist_cnt_d    = hist_cnt_q;
    hist_wr_en    = 1'b0;
    last_cell_d   = last_cell_q;
    last_player_d = last_player_q;
    code_d        = code_q;
    accept_d      = 1'b0;
    illegal_d     = 1'b0;
    undo_done_d   = 1'b0;
    undo_err_d    = 1'b0;
    if (clear) begin
      board_d       = '0;
      count_d       = '0;
      hist_ptr_d    = '0;
      hist_cnt_d    = '0;
      last_cell_d   = '0;
      last_player_d = '0;
    end else if (state_q == StCheck) begin
      if (range_bad) begin
        illegal_d = 1'b1;
        code_d    = 2'b01;
      end else if (player_bad) begin
        illegal_d = 1'b1;
        code_d    = 2'b11;
      end else if (occupied) begin
        illegal_d = 1'b1;
        code_d    = 2'b10;
      end else begin
        board_d[32'(req_cell_q)*PW +: PW] = req_player_q;
        count_d       = count_q + 1'b1;
        hist_wr_en    = 1'b1;
        hist_ptr_d    = ptr_inc(hist_ptr_q);
        // Saturating count: a full ring overwrites its oldest entry
        hist_cnt_d    = (hist_cnt_q == NW'(HIST_DEPTH)) ? hist_cnt_q : hist_cnt_q + 1'b1;
        last_cell_d   = req_cell_q;
        last_player_d = req_player_q;
        accept_d      = 1'b1;
      end
    end else if (undo_req) begin
      if (hist_cnt_q == '0) begin
        undo_err_d = 1'b1;
      end else begin
        board_d[32'(top_entry[EW-1:PW])*PW +: PW] = '0;
        count_d     = count_q - 1'b1;
        hist_ptr_d  = top_idx;
        hist_cnt_d  = hist_cnt_q - 1'b1;
        undo_done_d = 1'b1;
        if (hist_cnt_q > NW'(1)) begin
          last_cell_d   = below_entry[EW-1:PW];
          last_player_d = below_entry[PW-1:0];
        end else begin
          last_cell_d   = '0;
          last_player_d = '0;
        end
      end
    end
  end

  // Datapath registers, request capture and history ring
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_cell_q    <= '0;
      req_player_q  <= '0;
      board_q       <= '0;
      count_q       <= '0;
      hist_ptr_q    <= '0;
      hist_cnt_q    <= '0;
      last_cell_q   <= '0;
      last_player_q <= '0;
      code_q        <= '0;
      accept_q      <= 1'b0;
      illegal_q     <= 1'b0;
      undo_done_q   <= 1'b0;
      undo_err_q    <= 1'b0;
      for (int i = 0; i < int'(HIST_DEPTH); i++) hist_q[i] <= '0;
    end else begin
      if (mv_valid && mv_ready) begin
        req_cell_q   <= mv_cell;
        req_player_q <= mv_player;
      end
      board_q       <= board_d;
      count_q       <= count_d;
      hist_ptr_q    <= hist_ptr_d;
      hist_cnt_q    <= hist_cnt_d;
      last_cell_q   <= last_cell_d;
      last_player_q <= last_player_d;
      code_q        <= code_d;
      accept_q      <= accept_d;
      illegal_q     <= illegal_d;
      undo_done_q   <= undo_done_d;
      undo_err_q    <= undo_err_d;
      if (hist_wr_en) hist_q[hist_ptr_q] <= {req_cell_q, req_player_q};
    end
  end

  assign board        = board_q;
  assign move_count   = count_q;
  assign board_full   = (count_q == CW'(CELLS));
  assign last_cell    = last_cell_q;
  assign last_player  = last_player_q;
  assign illegal_code = code_q;
  assign mv_accept    = accept_q;
  assign mv_illegal   = illegal_q;
  assign undo_done    = undo_done_q;
  assign undo_err     = undo_err_q;

endmodule

// File: tb/tb_board_position_file.sv
// Bench for board_position_file: two instances (deep and 2-entry history) share
// the stimulus; a queue-style board model is checked every cycle, plus literals.
module tb_board_position_file;

  localparam int D1 = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic clear, mv_valid, undo_req;
  logic [3:0] mv_cell;
  logic [1:0] mv_player;

  logic        ready_o [2];
  logic        acc_o   [2];
  logic        ill_o   [2];
  logic [1:0]  code_o  [2];
  logic        ud_o    [2];
  logic        ue_o    [2];
  logic [17:0] board_o [2];
  logic [3:0]  cnt_o   [2];
  logic        full_o  [2];
  logic [3:0]  lc_o    [2];
  logic [1:0]  lp_o    [2];

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  board_position_file #(.HIST_DEPTH(9)) dut0 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .mv_valid(mv_valid),
    .mv_ready(ready_o[0]), .mv_cell(mv_cell), .mv_player(mv_player), .undo_req(undo_req),
    .mv_accept(acc_o[0]), .mv_illegal(ill_o[0]), .illegal_code(code_o[0]),
    .undo_done(ud_o[0]), .undo_err(ue_o[0]), .board(board_o[0]), .move_count(cnt_o[0]),
    .board_full(full_o[0]), .last_cell(lc_o[0]), .last_player(lp_o[0])
  );

  board_position_file #(.HIST_DEPTH(D1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .mv_valid(mv_valid),
    .mv_ready(ready_o[1]), .mv_cell(mv_cell), .mv_player(mv_player), .undo_req(undo_req),
    .mv_accept(acc_o[1]), .mv_illegal(ill_o[1]), .illegal_code(code_o[1]),
    .undo_done(ud_o[1]), .undo_err(ue_o[1]), .board(board_o[1]), .move_count(cnt_o[1]),
    .board_full(full_o[1]), .last_cell(lc_o[1]), .last_player(lp_o[1])
  );

  // Model: board as plain cell array, history as an oldest-first list
  int m_board [2][9];
  int m_hc [2][9];
  int m_hp [2][9];
  int m_hn [2];
  int m_lc [2];
  int m_lp [2];
  int m_code [2];
  bit m_acc [2];
  bit m_ill [2];
  bit m_ud [2];
  bit m_ue [2];
  bit m_pend [2];
  int m_pc [2];
  int m_pp [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 9 : D1;
  endfunction

  function automatic logic [17:0] m_vec(input int k);
    logic [17:0] v = '0;
    for (int i = 0; i < 9; i++) v[i*2 +: 2] = 2'(m_board[k][i]);
    return v;
  endfunction

  function automatic int m_count(input int k);
    int n = 0;
    for (int i = 0; i < 9; i++) if (m_board[k][i] != 0) n++;
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 9; i++) m_board[k][i] = 0;
        m_hn[k] = 0; m_lc[k] = 0; m_lp[k] = 0; m_code[k] = 0; m_pend[k] = 0;
        m_acc[k] = 0; m_ill[k] = 0; m_ud[k] = 0; m_ue[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_ill[k] = 0; m_ud[k] = 0; m_ue[k] = 0;
        if (clear) begin
          for (int i = 0; i < 9; i++) m_board[k][i] = 0;
          m_hn[k] = 0; m_lc[k] = 0; m_lp[k] = 0; m_pend[k] = 0;
        end else if (m_pend[k]) begin
          m_pend[k] = 0;
          if (m_pc[k] >= 9) begin
            m_ill[k] = 1; m_code[k] = 1;
          end else if (m_pp[k] == 0 || m_pp[k] > 2) begin
            m_ill[k] = 1; m_code[k] = 3;
          end else if (m_board[k][m_pc[k]] != 0) begin
            m_ill[k] = 1; m_code[k] = 2;
          end else begin
            m_board[k][m_pc[k]] = m_pp[k];
            if (m_hn[k] == depth_of(k)) begin
              for (int j = 0; j < depth_of(k) - 1; j++) begin
                m_hc[k][j] = m_hc[k][j+1];
                m_hp[k][j] = m_hp[k][j+1];
              end
              m_hn[k]--;
            end
            m_hc[k][m_hn[k]] = m_pc[k];
            m_hp[k][m_hn[k]] = m_pp[k];
            m_hn[k]++;
            m_lc[k] = m_pc[k]; m_lp[k] = m_pp[k]; m_acc[k] = 1;
          end
        end else if (undo_req) begin
          if (m_hn[k] == 0) begin
            m_ue[k] = 1;
          end else begin
            m_hn[k]--;
            m_board[k][m_hc[k][m_hn[k]]] = 0;
            m_ud[k] = 1;
            m_lc[k] = (m_hn[k] > 0) ? m_hc[k][m_hn[k]-1] : 0;
            m_lp[k] = (m_hn[k] > 0) ? m_hp[k][m_hn[k]-1] : 0;
          end
        end else if (mv_valid) begin
          m_pend[k] = 1; m_pc[k] = int'(mv_cell); m_pp[k] = int'(mv_player);
        end
      end
    end
  end

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got 0x%0h want 0x%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check("board", k, 32'(board_o[k]), 32'(m_vec(k)));
        check("move_count", k, 32'(cnt_o[k]), m_count(k));
        check("board_full", k, 32'(full_o[k]), 32'(m_count(k) == 9));
        check("mv_ready", k, 32'(ready_o[k]), 32'(!m_pend[k] && !clear && !undo_req));
        check("mv_accept", k, 32'(acc_o[k]), 32'(m_acc[k]));
        check("mv_illegal", k, 32'(ill_o[k]), 32'(m_ill[k]));
        check("illegal_code", k, 32'(code_o[k]), m_code[k]);
        check("undo_done", k, 32'(ud_o[k]), 32'(m_ud[k]));
        check("undo_err", k, 32'(ue_o[k]), 32'(m_ue[k]));
        check("last_cell", k, 32'(lc_o[k]), m_lc[k]);
        check("last_player", k, 32'(lp_o[k]), m_lp[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns one cycle after the commit edge, when the result pulse is visible
  task automatic move(input int c, input int p);
    mv_valid = 1'b1; mv_cell = 4'(c); mv_player = 2'(p);
    tick();
    mv_valid = 1'b0;
    tick();
  endtask

  task automatic undo();
    undo_req = 1'b1;
    tick();
    undo_req = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    clear = 0; mv_valid = 0; mv_cell = 0; mv_player = 0; undo_req = 0;
    #2 reset_n = 1'b0;
    chk_en = 1;
    tick(); tick();
    check("rst_board", 0, 32'(board_o[0]), 0);
    check("rst_count", 0, 32'(cnt_o[0]), 0);
    check("rst_code", 0, 32'(code_o[0]), 0);
    reset_n = 1'b1;
    tick();

    // First legal move: cell 4 by player 1
    mv_valid = 1; mv_cell = 4; mv_player = 1;
    check("ready_idle", 0, 32'(ready_o[0]), 1);
    tick();
    mv_valid = 0;
    check("ready_check", 0, 32'(ready_o[0]), 0);
    check("acc_early", 0, 32'(acc_o[0]), 0);
    tick();
    check("acc_first", 0, 32'(acc_o[0]), 1);
    check("board_first", 0, 32'(board_o[0]), 32'h100);
    check("count_first", 0, 32'(cnt_o[0]), 1);
    check("lc_first", 0, 32'(lc_o[0]), 4);
    tick();
    check("acc_oneshot", 0, 32'(acc_o[0]), 0);

    // Rejections in priority order
    move(4, 2); check("occ_code", 0, 32'(code_o[0]), 2);
    check("occ_board", 0, 32'(board_o[0]), 32'h100);
    move(9, 1); check("range_code", 0, 32'(code_o[0]), 1);
    move(2, 0); check("p0_code", 0, 32'(code_o[0]), 3);
    move(2, 3); check("p3_code", 0, 32'(code_o[0]), 3);
    move(12, 0); check("range_first", 0, 32'(code_o[0]), 1);
    check("ill_pulse", 0, 32'(ill_o[0]), 1);

    // Fill the board: even cells player 1, odd cells player 2
    for (int c = 0; c < 9; c++) if (c != 4) move(c, (c % 2) + 1);
    check("full_flag", 0, 32'(full_o[0]), 1);
    check("full_count", 0, 32'(cnt_o[0]), 9);
    check("full_board", 0, 32'(board_o[0]), 32'h19999);
    move(0, 2);
    check("full_reject", 0, 32'(code_o[0]), 2);

    // Clear together with a move request
    clear = 1; mv_valid = 1; mv_cell = 5; mv_player = 1;
    #1 check("ready_clear", 0, 32'(ready_o[0]), 0);
    tick();
    clear = 0; mv_valid = 0;
    check("clear_board", 0, 32'(board_o[0]), 0);
    tick();
    check("clear_noacc", 0, 32'(acc_o[0]), 0);

    // Undo sequence
    move(0, 1); move(4, 2); move(8, 1);
    undo();
    check("undo1_board", 0, 32'(board_o[0]), 32'h201);
    check("undo1_lc", 0, 32'(lc_o[0]), 4);
    undo();
    check("undo2_board", 0, 32'(board_o[0]), 32'h001);
    undo();
    check("undo3_count", 0, 32'(cnt_o[0]), 0);
    check("undo3_err_d1", 1, 32'(ue_o[1]), 1);
    check("undo3_board_d1", 1, 32'(board_o[1]), 32'h001);
    undo();
    check("undo4_err", 0, 32'(ue_o[0]), 1);
    do_clear();

    // Circular history on the shallow instance
    move(1, 1); move(2, 2); move(3, 1);
    undo(); check("circ1_board", 1, 32'(board_o[1]), 32'h24);
    undo(); check("circ2_lc", 1, 32'(lc_o[1]), 0);
    undo();
    check("circ3_err", 1, 32'(ue_o[1]), 1);
    check("circ3_board", 1, 32'(board_o[1]), 32'h4);
    check("circ3_count", 1, 32'(cnt_o[1]), 1);
    do_clear();

    // Clear while a move is pending
    mv_valid = 1; mv_cell = 5; mv_player = 1;
    tick();
    mv_valid = 0; clear = 1;
    tick();
    clear = 0;
    check("chk_clear_acc", 0, 32'(acc_o[0]), 0);
    check("chk_clear_board", 0, 32'(board_o[0]), 0);
    tick();

    // Undo beats a simultaneous move request
    move(5, 1);
    undo_req = 1; mv_valid = 1; mv_cell = 6; mv_player = 2;
    #1 check("ready_undo", 0, 32'(ready_o[0]), 0);
    tick();
    undo_req = 0; mv_valid = 0;
    check("undo_win", 0, 32'(ud_o[0]), 1);
    tick();
    check("undo_nomove", 0, 32'(board_o[0]), 0);

    // Asynchronous reset in the middle of a check
    move(3, 2);
    check("pre_reset", 0, 32'(board_o[0]), 32'h80);
    mv_valid = 1; mv_cell = 7; mv_player = 1;
    tick();
    mv_valid = 0;
    #2 reset_n = 1'b0;
    #1 check("async_board", 0, 32'(board_o[0]), 0);
    check("async_acc", 0, 32'(acc_o[0]), 0);
    check("async_board_d1", 1, 32'(board_o[1]), 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_acc", 0, 32'(acc_o[0]), 0);
    tick(); tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
